program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter RAM_ADDR_WIDTH, default 16, RAM address width.
REQ-002 SHALL have parameter RAM_DATA_WIDTH, default 32, RAM word width.
REQ-003 SHALL have parameter LOAD_BASE, default 1, RAM address of the first program word.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 start  in  1  single-cycle pulse that begins a load; honoured only in IDLE or DONE.
REQ-008 byte_in  in  8  serial program byte, MSB-first within each word.
REQ-009 byte_valid  in  1  byte_in is valid.
REQ-010 byte_ready  out  1  loader accepts a byte this cycle; transfer occurs when byte_valid and byte_ready are both 1.
REQ-011 ram_external_control_enable  out  1  gives the processor RAM port to the loader.
REQ-012 external_ram_enable, external_ram_write_enable, external_ram_read_enable  out  1 each  RAM strobes; read enable is always 0.
REQ-013 external_ram_addr  out  RAM_ADDR_WIDTH  RAM write address.
REQ-014 external_ram_write_data  out  RAM_DATA_WIDTH  RAM write data.
REQ-015 core_reset  out  1  reset driven to the processor core.
REQ-016 control_enable, pc_enable, ram_enable  out  1 each  processor run enables.
REQ-017 busy, done, error  out  1 each  loader status.

Function
REQ-018 States SHALL be IDLE, LEN, DATA, WRITE, DONE and ERR.
- IDLE -> LEN on start.
- LEN: collects 4 bytes into word count N (bits 15:0; upper 16 bits ignored). -> ERR if N==0 or N > 2^RAM_ADDR_WIDTH - LOAD_BASE; else -> DATA.
- DATA: collects 4 bytes into one data word, then -> WRITE.
- WRITE: lasts exactly 1 cycle, then -> DATA if words remain, else -> DONE.
- DONE and ERR: -> LEN on start.
REQ-019 byte_ready SHALL be 1 only in LEN and DATA; the byte accepted on a cycle's clock edge is the one presented on that cycle.
REQ-020 Bytes SHALL be assembled MSB-first: the first accepted byte lands in bits 31:24.
REQ-021 A 2-bit byte counter SHALL wrap 3->0 on the 4th accepted byte, and the state transition SHALL occur on that same edge.
REQ-022 WRITE SHALL drive external_ram_enable=1 and external_ram_write_enable=1 for exactly one cycle, with the address and data stable in that cycle.
REQ-023 The first word SHALL be written at LOAD_BASE; the address SHALL increment by 1 after each WRITE.
REQ-024 WRITE latency SHALL be 1 cycle after the edge that accepts the 4th byte of a word.
REQ-025 In LEN, DATA and WRITE: ram_external_control_enable=1, core_reset=1, busy=1.
REQ-026 In DONE: ram_external_control_enable=0, core_reset=0, control_enable=1, pc_enable=1, ram_enable=1, done=1, busy=0.
REQ-027 In ERR: error=1, core_reset=1, run enables=0, ram_external_control_enable=0, no RAM writes.
REQ-028 A start from DONE or ERR SHALL immediately reassert core_reset and clear the run enables on the same edge that enters LEN.
REQ-029 A start in LEN, DATA or WRITE SHALL be ignored.
REQ-030 byte_valid SHALL be ignored while byte_ready=0.

Reset
REQ-031 While reset=1 on a clock edge, the next state SHALL be IDLE, with:
- counters, address and data cleared to 0;
- core_reset=1;
- every other output 0, including byte_ready.
REQ-032 A reset received mid-load SHALL abort the load; words already written are not undone.

Structure
REQ-033 State encoding and the LOAD_BASE default SHALL live in the shared ceyloniac package, alongside the existing width constants.
REQ-034 The byte-to-word shift register and byte counter SHALL form one natural sub-module, word_assembler.

Verification
REQ-035 Load of N=2 words:
- stimulus: bytes 00 00 00 02, then 20 01 00 05, then AC 01 00 00, back to back;
- required: writes addr1=0x20010005 and addr2=0xAC010000, each with a 1-cycle write_enable pulse, then done=1, core_reset=0, control_enable=1.
REQ-036 byte_valid toggled every other cycle during the same load -> identical writes; byte_ready=0 in both WRITE cycles.
REQ-037 Count word 0x00000000 -> ERR: error=1, no write strobes, core_reset stays 1.
REQ-038 reset asserted after the 2nd byte of data word 1 -> next cycle IDLE with core_reset=1, byte_ready=0; a subsequent start plus a full N=1 load writes at addr1.
REQ-039 start pulsed in DONE, then N=1 word 0xFFFFFFFF -> core_reset=1 on the start edge; write addr1=0xFFFFFFFF; done=1 again.
REQ-040 Count word 0x0000FFFF with LOAD_BASE=1 -> accepted; count word 0x00010000 (low 16 bits 0) -> ERR.

Source files
------------

// File: rtl/ceyloniac_pkg.sv
// Shared ceyloniac definitions: bus widths, loader state encoding and the
// default RAM address of the first loaded program word.
package ceyloniac_pkg;

    localparam int CEY_RAM_ADDR_WIDTH = 16;
    localparam int CEY_RAM_DATA_WIDTH = 32;
    localparam int LOAD_BASE_DEFAULT  = 1;
    localparam int BYTES_PER_WORD     = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_WRITE,
        ST_DONE,
        ST_ERR
    } loader_state_t;

    // A word count is usable only if it is non-zero and every word fits
    // between the load base and the top of the RAM address space.
    function automatic logic count_in_range(input logic [15:0] count,
                                            input int         addr_width,
                                            input int         load_base);
        logic [32:0] limit;
        logic [32:0] count_ext;
        limit     = (33'd1 << addr_width) - 33'(load_base);
        count_ext = {17'd0, count};
        return (count != 16'd0) && (count_ext <= limit);
    endfunction

endpackage

// File: rtl/program_loader_word_assembler.sv
// Collects four serial bytes MSB-first into a 32-bit word and flags the
// byte that completes the word.
module word_assembler
    import ceyloniac_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic [15:0] word_next_low,
    output logic        word_complete
);

    logic [1:0] byte_cnt;

    // The low half of the word as it will look once the current byte is
    // shifted in; the loader needs it on the same edge to judge the count.
    assign word_next_low = {word[7:0], byte_in};
    assign word_complete = shift_en && (byte_cnt == 2'd3);

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt <= 2'd0;
            word     <= 32'd0;
        end else if (clear) begin
            byte_cnt <= 2'd0;
        end else if (shift_en) begin
            word     <= {word[23:0], byte_in};
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Serial program loader: takes a word count and program words over a byte
// stream, writes them into processor RAM, then releases the core to run.
module program_loader
    import ceyloniac_pkg::*;
#(
    parameter int RAM_ADDR_WIDTH = CEY_RAM_ADDR_WIDTH,
    parameter int RAM_DATA_WIDTH = CEY_RAM_DATA_WIDTH,
    parameter int LOAD_BASE      = LOAD_BASE_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [7:0]                byte_in,
    input  logic                      byte_valid,
    output logic                      byte_ready,
    output logic                      ram_external_control_enable,
    output logic                      external_ram_enable,
    output logic                      external_ram_write_enable,
    output logic                      external_ram_read_enable,
    output logic [RAM_ADDR_WIDTH-1:0] external_ram_addr,
    output logic [RAM_DATA_WIDTH-1:0] external_ram_write_data,
    output logic                      core_reset,
    output logic                      control_enable,
    output logic                      pc_enable,
    output logic                      ram_enable,
    output logic                      busy,
    output logic                      done,
    output logic                      error
);

    loader_state_t             state;
    loader_state_t             next_state;
    logic [15:0]               words_left;
    logic [RAM_ADDR_WIDTH-1:0] addr_q;
    logic [31:0]               assembled_word;
    logic [15:0]               word_next_low;
    logic                      word_complete;
    logic                      byte_accept;
    logic                      start_ok;

    assign byte_accept = byte_valid && byte_ready;
    assign start_ok    = start && ((state == ST_IDLE) || (state == ST_DONE) ||
                                   (state == ST_ERR));

    word_assembler u_word_assembler (
        .clk           (clk),
        .reset         (reset),
        .clear         (start_ok),
        .shift_en      (byte_accept),
        .byte_in       (byte_in),
        .word          (assembled_word),
        .word_next_low (word_next_low),
        .word_complete (word_complete)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            words_left <= 16'd0;
            addr_q     <= '0;
        end else begin
            state <= next_state;
            if (start_ok) begin
                addr_q     <= RAM_ADDR_WIDTH'(LOAD_BASE);
                words_left <= 16'd0;
            end
            if ((state == ST_LEN) && word_complete) begin
                words_left <= word_next_low;
            end
            if (state == ST_WRITE) begin
                addr_q     <= addr_q + 1'b1;
                words_left <= words_left - 16'd1;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) next_state = ST_LEN;
            end
            ST_LEN: begin
                if (word_complete) begin
                    if (count_in_range(word_next_low, RAM_ADDR_WIDTH, LOAD_BASE))
                        next_state = ST_DATA;
                    else
                        next_state = ST_ERR;
                end
            end
            ST_DATA: begin
                if (word_complete) next_state = ST_WRITE;
            end
            ST_WRITE: begin
                next_state = (words_left == 16'd1) ? ST_DONE : ST_DATA;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // The core is held in reset everywhere except DONE, so a fresh start
    // from DONE stops the previously loaded program on the same edge.
    always_comb begin
        byte_ready                  = 1'b0;
        ram_external_control_enable = 1'b0;
        external_ram_enable         = 1'b0;
        external_ram_write_enable   = 1'b0;
        core_reset                  = 1'b1;
        control_enable              = 1'b0;
        pc_enable                   = 1'b0;
        ram_enable                  = 1'b0;
        busy                        = 1'b0;
        done                        = 1'b0;
        error                       = 1'b0;
        case (state)
            ST_LEN, ST_DATA: begin
                byte_ready                  = 1'b1;
                ram_external_control_enable = 1'b1;
                busy                        = 1'b1;
            end
            ST_WRITE: begin
                ram_external_control_enable = 1'b1;
                external_ram_enable         = 1'b1;
                external_ram_write_enable   = 1'b1;
                busy                        = 1'b1;
            end
            ST_DONE: begin
                core_reset     = 1'b0;
                control_enable = 1'b1;
                pc_enable      = 1'b1;
                ram_enable     = 1'b1;
                done           = 1'b1;
            end
            ST_ERR: begin
                error = 1'b1;
            end
            default: ;
        endcase
    end

    assign external_ram_read_enable = 1'b0;
    assign external_ram_addr        = addr_q;
    assign external_ram_write_data  = RAM_DATA_WIDTH'(assembled_word);

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader: loads, error counts,
// mid-load reset and restart from DONE, with a RAM write log.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        ram_external_control_enable;
    logic        external_ram_enable;
    logic        external_ram_write_enable;
    logic        external_ram_read_enable;
    logic [15:0] external_ram_addr;
    logic [31:0] external_ram_write_data;
    logic        core_reset;
    logic        control_enable;
    logic        pc_enable;
    logic        ram_enable;
    logic        busy;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;

    int          wr_count       = 0;
    int          long_pulses    = 0;
    int          ready_in_write = 0;
    int          read_strobes   = 0;
    int          we_without_en  = 0;
    logic        prev_we        = 1'b0;
    logic [15:0] wr_addr [0:31];
    logic [31:0] wr_data [0:31];
    int          base;

    program_loader dut (
        .clk                         (clk),
        .reset                       (reset),
        .start                       (start),
        .byte_in                     (byte_in),
        .byte_valid                  (byte_valid),
        .byte_ready                  (byte_ready),
        .ram_external_control_enable (ram_external_control_enable),
        .external_ram_enable         (external_ram_enable),
        .external_ram_write_enable   (external_ram_write_enable),
        .external_ram_read_enable    (external_ram_read_enable),
        .external_ram_addr           (external_ram_addr),
        .external_ram_write_data     (external_ram_write_data),
        .core_reset                  (core_reset),
        .control_enable              (control_enable),
        .pc_enable                   (pc_enable),
        .ram_enable                  (ram_enable),
        .busy                        (busy),
        .done                        (done),
        .error                       (error)
    );

    always #5 clk = ~clk;

    // RAM write log, sampled mid-cycle away from the active edge.
    always @(negedge clk) begin
        if (external_ram_write_enable) begin
            if (wr_count < 32) begin
                wr_addr[wr_count[4:0]] = external_ram_addr;
                wr_data[wr_count[4:0]] = external_ram_write_data;
            end
            wr_count = wr_count + 1;
            if (prev_we) long_pulses = long_pulses + 1;
            if (byte_ready) ready_in_write = ready_in_write + 1;
            if (!external_ram_enable) we_without_en = we_without_en + 1;
        end
        if (external_ram_read_enable) read_strobes = read_strobes + 1;
        prev_we = external_ram_write_enable;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks = checks + 1;
        assert (observed === expected)
        else begin
            errors = errors + 1;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Present one byte and hold it until the loader takes it.
    task automatic applyStimulus(input logic [7:0] b);
        int guard;
        guard      = 0;
        byte_in    = b;
        byte_valid = 1'b1;
        while (!byte_ready && guard < 50) begin
            tick;
            guard = guard + 1;
        end
        if (guard >= 50) begin
            checks = checks + 1;
            errors = errors + 1;
            $error("[TB] FAIL byte_timeout observed=0x%0h expected=accept", b);
        end else begin
            tick;
        end
        byte_valid = 1'b0;
    endtask

    task automatic sendWord(input logic [31:0] w, input bit gap);
        for (int i = 3; i >= 0; i--) begin
            applyStimulus(w[i*8 +: 8]);
            if (gap) tick;
        end
    endtask

    task automatic pulseStart;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic waitDone(input string tag);
        int guard;
        guard = 0;
        while (!done && guard < 20) begin
            tick;
            guard = guard + 1;
        end
        checkOutput(tag, {31'd0, done}, 32'd1);
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        tick;
        tick;

        // Reset state
        checkOutput("rst_core_reset", {31'd0, core_reset}, 32'd1);
        checkOutput("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_error", {31'd0, error}, 32'd0);
        checkOutput("rst_ext_ctrl", {31'd0, ram_external_control_enable}, 32'd0);
        checkOutput("rst_run_en", {29'd0, control_enable, pc_enable, ram_enable}, 32'd0);
        checkOutput("rst_addr", {16'd0, external_ram_addr}, 32'd0);
        checkOutput("rst_data", external_ram_write_data, 32'd0);
        reset = 1'b0;
        tick;

        // N=2 load, bytes back to back
        base = wr_count;
        pulseStart;
        checkOutput("len_busy", {31'd0, busy}, 32'd1);
        checkOutput("len_ext_ctrl", {31'd0, ram_external_control_enable}, 32'd1);
        checkOutput("len_byte_ready", {31'd0, byte_ready}, 32'd1);
        sendWord(32'h0000_0002, 1'b0);
        sendWord(32'h2001_0005, 1'b0);
        checkOutput("w1_we", {31'd0, external_ram_write_enable}, 32'd1);
        checkOutput("w1_en", {31'd0, external_ram_enable}, 32'd1);
        checkOutput("w1_addr", {16'd0, external_ram_addr}, 32'd1);
        checkOutput("w1_data", external_ram_write_data, 32'h2001_0005);
        checkOutput("w1_byte_ready", {31'd0, byte_ready}, 32'd0);
        sendWord(32'hAC01_0000, 1'b0);
        checkOutput("w2_addr", {16'd0, external_ram_addr}, 32'd2);
        checkOutput("w2_data", external_ram_write_data, 32'hAC01_0000);
        tick;
        checkOutput("n2_done", {31'd0, done}, 32'd1);
        checkOutput("n2_core_reset", {31'd0, core_reset}, 32'd0);
        checkOutput("n2_run_en", {29'd0, control_enable, pc_enable, ram_enable}, 32'd7);
        checkOutput("n2_busy", {31'd0, busy}, 32'd0);
        checkOutput("n2_ext_ctrl", {31'd0, ram_external_control_enable}, 32'd0);
        checkOutput("n2_wr_count", wr_count - base, 32'd2);
        checkOutput("n2_log_addr1", {16'd0, wr_addr[base[4:0]]}, 32'd1);
        checkOutput("n2_log_data1", wr_data[base[4:0]], 32'h2001_0005);
        checkOutput("n2_log_addr2", {16'd0, wr_addr[5'(base + 1)]}, 32'd2);
        checkOutput("n2_log_data2", wr_data[5'(base + 1)], 32'hAC01_0000);

        // Same load with byte_valid toggling, restarted from DONE
        base = wr_count;
        pulseStart;
        checkOutput("restart_core_reset", {31'd0, core_reset}, 32'd1);
        checkOutput("restart_run_en", {29'd0, control_enable, pc_enable, ram_enable}, 32'd0);
        checkOutput("restart_done", {31'd0, done}, 32'd0);
        sendWord(32'h0000_0002, 1'b1);
        sendWord(32'h2001_0005, 1'b1);
        sendWord(32'hAC01_0000, 1'b1);
        waitDone("tog_done");
        checkOutput("tog_wr_count", wr_count - base, 32'd2);
        checkOutput("tog_log_addr1", {16'd0, wr_addr[base[4:0]]}, 32'd1);
        checkOutput("tog_log_data1", wr_data[base[4:0]], 32'h2001_0005);
        checkOutput("tog_log_addr2", {16'd0, wr_addr[5'(base + 1)]}, 32'd2);
        checkOutput("tog_log_data2", wr_data[5'(base + 1)], 32'hAC01_0000);
        checkOutput("ready_in_write", ready_in_write, 32'd0);

        // N=1 load of all-ones word from DONE
        base = wr_count;
        pulseStart;
        checkOutput("ff_start_core_reset", {31'd0, core_reset}, 32'd1);
        sendWord(32'h0000_0001, 1'b0);
        sendWord(32'hFFFF_FFFF, 1'b0);
        checkOutput("ff_we", {31'd0, external_ram_write_enable}, 32'd1);
        checkOutput("ff_addr", {16'd0, external_ram_addr}, 32'd1);
        checkOutput("ff_data", external_ram_write_data, 32'hFFFF_FFFF);
        tick;
        checkOutput("ff_done", {31'd0, done}, 32'd1);
        checkOutput("ff_wr_count", wr_count - base, 32'd1);

        // Zero word count goes to ERR without writing
        base = wr_count;
        pulseStart;
        sendWord(32'h0000_0000, 1'b0);
        checkOutput("zero_error", {31'd0, error}, 32'd1);
        checkOutput("zero_core_reset", {31'd0, core_reset}, 32'd1);
        checkOutput("zero_busy", {31'd0, busy}, 32'd0);
        checkOutput("zero_byte_ready", {31'd0, byte_ready}, 32'd0);
        checkOutput("zero_ext_ctrl", {31'd0, ram_external_control_enable}, 32'd0);
        tick;
        tick;
        tick;
        checkOutput("zero_still_error", {31'd0, error}, 32'd1);
        checkOutput("zero_no_write", wr_count - base, 32'd0);

        // Count 0x00010000 has zero low half, so it is rejected from ERR
        base = wr_count;
        pulseStart;
        checkOutput("big_leaves_err", {31'd0, error}, 32'd0);
        sendWord(32'h0001_0000, 1'b0);
        checkOutput("big_error", {31'd0, error}, 32'd1);
        tick;
        checkOutput("big_no_write", wr_count - base, 32'd0);

        // Reset in the middle of a data word aborts the load
        base = wr_count;
        pulseStart;
        sendWord(32'h0000_0001, 1'b0);
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        checkOutput("abort_byte_ready", {31'd0, byte_ready}, 32'd0);
        checkOutput("abort_core_reset", {31'd0, core_reset}, 32'd1);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_error", {31'd0, error}, 32'd0);
        checkOutput("abort_addr", {16'd0, external_ram_addr}, 32'd0);
        checkOutput("abort_data", external_ram_write_data, 32'd0);
        tick;
        checkOutput("abort_stays_idle", {31'd0, byte_ready}, 32'd0);
        pulseStart;
        sendWord(32'h0000_0001, 1'b0);
        applyStimulus(8'hDE);
        applyStimulus(8'hAD);
        pulseStart;
        checkOutput("ignored_start_busy", {31'd0, byte_ready}, 32'd1);
        applyStimulus(8'hBE);
        applyStimulus(8'hEF);
        checkOutput("reload_we", {31'd0, external_ram_write_enable}, 32'd1);
        checkOutput("reload_addr", {16'd0, external_ram_addr}, 32'd1);
        checkOutput("reload_data", external_ram_write_data, 32'hDEAD_BEEF);
        waitDone("reload_done");
        checkOutput("reload_wr_count", wr_count - base, 32'd1);

        // Largest count for LOAD_BASE=1 is accepted
        pulseStart;
        sendWord(32'h0000_FFFF, 1'b0);
        checkOutput("max_error", {31'd0, error}, 32'd0);
        checkOutput("max_busy", {31'd0, busy}, 32'd1);
        checkOutput("max_byte_ready", {31'd0, byte_ready}, 32'd1);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        tick;

        checkOutput("long_pulses", long_pulses, 32'd0);
        checkOutput("we_without_en", we_without_en, 32'd0);
        checkOutput("read_strobes", read_strobes, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
